// File: rtl/usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_ctrl
//
// Receive-side packet controller for a USB full-speed style receiver. It sits
// behind the edge detector, the bit sampler and the 8-bit shift register, and
// decides which received bytes are written to the RX FIFO. It also tracks
// packet framing: SYNC byte, data bytes, EOP position and byte-count overflow.
//
// Handshake: every input strobe (d_edge, shift_enable, byte_received) is a
// one-cycle pulse that is consumed in the cycle it is high. There is no
// backpressure. w_enable is a one-cycle write strobe, and rcv_data is only
// meaningful in the cycle byte_received is high.
//
// Parameters
//   MAX_BYTES    maximum data bytes accepted per packet after SYNC
//   TIMEOUT_CYC  idle cycles without shift_enable before the packet is aborted
//
// Build option
//   RX_TIMEOUT_EN  when defined, SYNC_RCV and RCV_DATA abort to ERR_IDLE after
//                  TIMEOUT_CYC consecutive cycles without shift_enable. When
//                  undefined, there is no timeout logic and the ports are the
//                  same.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   d_edge         pulse on a D+/D- transition
//   eop            high while SE0 is seen on the bus
//   shift_enable   pulse at each bit-sample point
//   byte_received  pulse when 8 bits have been shifted in
//   rcv_data       byte that completed with byte_received
//   rcving         high while a packet is in progress
//   w_enable       one-cycle FIFO write strobe for rcv_data
//   r_error        sticky packet error flag, cleared at the next packet start
//   byte_cnt       data bytes stored in the current packet
//
// The FSM register is named 'state' so that checkers can bind to it
// hierarchically.
// -----------------------------------------------------------------------------
module usb_rx_ctrl #(
    parameter int MAX_BYTES   = 64,
    parameter int TIMEOUT_CYC = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic [6:0] byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC_RCV,
        RCV_DATA,
        STORE,
        EOP_WAIT,
        ERR_DRAIN,
        ERR_IDLE
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

    state_t     state;
    logic [2:0] bit_cnt;
    logic       eop_latched;   // EOP seen in the same cycle as byte_received
    logic       eop_bit;       // SE0 at a bit-sample point
    logic [7:0] cnt_next;      // one bit wider so the overflow compare cannot wrap
    logic       timeout_hit;

    assign eop_bit  = eop & shift_enable;
    assign cnt_next = {1'b0, byte_cnt} + 8'd1;

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires in the TIMEOUT_CYC-th consecutive cycle without a sample point.
    assign timeout_hit = !shift_enable && (tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == SYNC_RCV || state == RCV_DATA) && !shift_enable) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    // Keep the timeout length as part of the parameter set even when the
    // counter is absent, so both builds take the same parameter overrides.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rcving      <= 1'b0;
            w_enable    <= 1'b0;
            r_error     <= 1'b0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            eop_latched <= 1'b0;
        end else begin
            w_enable <= 1'b0;

            // The bit position is only tracked inside a packet. byte_received
            // wins over a coincident shift_enable because it closes the byte.
            if (state != IDLE) begin
                if (byte_received) begin
                    bit_cnt <= '0;
                end else if (shift_enable) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (d_edge) begin
                        state       <= SYNC_RCV;
                        rcving      <= 1'b1;
                        r_error     <= 1'b0;
                        byte_cnt    <= '0;
                        bit_cnt     <= '0;
                        eop_latched <= 1'b0;
                    end
                end

                SYNC_RCV: begin
                    if (byte_received) begin
                        if (rcv_data == 8'h80) begin
                            state <= RCV_DATA;
                        end else begin
                            state   <= ERR_DRAIN;
                            r_error <= 1'b1;
                        end
                    end else if (eop_bit || timeout_hit) begin
                        state   <= ERR_IDLE;
                        r_error <= 1'b1;
                    end
                end

                RCV_DATA: begin
                    if (byte_received) begin
                        // The byte is stored first. A coincident EOP is kept
                        // for the decision taken in STORE.
                        state       <= STORE;
                        w_enable    <= 1'b1;
                        eop_latched <= eop_bit;
                    end else if (eop_bit) begin
                        if (bit_cnt == 3'd0) begin
                            state <= EOP_WAIT;
                        end else begin
                            state   <= ERR_IDLE;     // EOP in the middle of a byte
                            r_error <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state   <= ERR_IDLE;
                        r_error <= 1'b1;
                    end
                end

                STORE: begin
                    byte_cnt    <= cnt_next[6:0];
                    eop_latched <= 1'b0;
                    if (eop_latched || eop_bit) begin
                        state <= EOP_WAIT;
                    end else if (cnt_next > MAX_B) begin
                        // The byte that overflows is still written. Only the
                        // bytes after it are dropped.
                        state   <= ERR_DRAIN;
                        r_error <= 1'b1;
                    end else begin
                        state <= RCV_DATA;
                    end
                end

                EOP_WAIT: begin
                    if (d_edge) begin
                        state  <= IDLE;
                        rcving <= 1'b0;
                    end
                end

                ERR_DRAIN: begin
                    r_error <= 1'b1;
                    if (eop_bit) begin
                        state <= ERR_IDLE;
                    end
                end

                ERR_IDLE: begin
                    r_error <= 1'b1;
                    if (d_edge) begin
                        state  <= IDLE;
                        rcving <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for usb_rx_ctrl. Two instances share one stimulus:
// 'dut' uses the default MAX_BYTES=64 and 'dut4' uses MAX_BYTES=4.
// The bench drives inputs #1 after each rising edge and checks outputs at the
// same point, which is well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_usb_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;

    logic       rcving,  w_enable,  r_error;
    logic [6:0] byte_cnt;
    logic       rcving4, w_enable4, r_error4;
    logic [6:0] byte_cnt4;

    int n_total = 0;
    int n_pass  = 0;
    int wr_cnt  = 0;
    int wr_cnt4 = 0;
    int wr_base;
    int wr_base4;

    usb_rx_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .byte_cnt      (byte_cnt)
    );

    usb_rx_ctrl #(.MAX_BYTES(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving4),
        .w_enable      (w_enable4),
        .r_error       (r_error4),
        .byte_cnt      (byte_cnt4)
    );

    // Clock and write-strobe counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_enable === 1'b1)  wr_cnt  = wr_cnt + 1;
        if (w_enable4 === 1'b1) wr_cnt4 = wr_cnt4 + 1;
    end

    // Comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // Driver tasks
    task automatic step(input logic de, input logic eo, input logic se,
                        input logic br, input logic [7:0] data);
        d_edge        = de;
        eop           = eo;
        shift_enable  = se;
        byte_received = br;
        rcv_data      = data;
        @(posedge clk);
        #1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // Eight sample points, then the byte_received pulse carrying the byte.
    task automatic send_byte(input logic [7:0] b);
        shifts(8);
        step(1'b0, 1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic send_eop();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic pulse_edge();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Directed sequence
    initial begin
        rst           = 1'b1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_rcving",   rcving,   0);
        chk("rst_w_enable", w_enable, 0);
        chk("rst_r_error",  r_error,  0);
        chk("rst_byte_cnt", byte_cnt, 0);

        // Good packet: SYNC, 0xA5, 0x3C, EOP on a byte boundary
        pulse_edge();
        chk("p1_rcving_start", rcving, 1);
        send_byte(8'h80);
        chk("p1_sync_no_write", w_enable, 0);
        send_byte(8'hA5);
        chk("p1_wr1_strobe", w_enable, 1);
        chk("p1_cnt_in_store", byte_cnt, 0);
        idle(1);
        chk("p1_wr1_one_cycle", w_enable, 0);
        chk("p1_cnt_1", byte_cnt, 1);
        send_byte(8'h3C);
        chk("p1_wr2_strobe", w_enable, 1);
        idle(1);
        chk("p1_wr2_one_cycle", w_enable, 0);
        chk("p1_cnt_2", byte_cnt, 2);
        send_eop();
        chk("p1_rcving_eop_wait", rcving, 1);
        pulse_edge();
        chk("p1_rcving_end", rcving, 0);
        chk("p1_r_error", r_error, 0);
        chk("p1_byte_cnt", byte_cnt, 2);
        chk("p1_writes", wr_cnt, 2);

        // Bad SYNC (0x81): drain without writes, error stays after the packet
        wr_base = wr_cnt;
        pulse_edge();
        send_byte(8'h81);
        chk("p2_err_set", r_error, 1);
        send_byte(8'h55);
        chk("p2_drain_no_write", w_enable, 0);
        send_eop();
        chk("p2_err_idle", r_error, 1);
        pulse_edge();
        chk("p2_rcving_end", rcving, 0);
        chk("p2_err_sticky", r_error, 1);
        chk("p2_writes", wr_cnt - wr_base, 0);

        // Partial byte before EOP
        pulse_edge();
        chk("p3_err_cleared", r_error, 0);
        send_byte(8'h80);
        send_byte(8'h11);
        chk("p3_wr_strobe", w_enable, 1);
        idle(1);
        shifts(3);
        send_eop();
        chk("p3_err_partial", r_error, 1);
        chk("p3_byte_cnt", byte_cnt, 1);
        chk("p3_rcving_err_idle", rcving, 1);
        pulse_edge();
        chk("p3_rcving_end", rcving, 0);

        // Overflow: 5 data bytes against MAX_BYTES=4
        wr_base  = wr_cnt;
        wr_base4 = wr_cnt4;
        pulse_edge();
        send_byte(8'h80);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            chk("p4_wr_strobe", w_enable4, 1);
            chk("p4_err_in_store", r_error4, 0);
            if (i < 5) idle(1);
        end
        idle(1);
        chk("p4_err_after_5th", r_error4, 1);
        chk("p4_cnt4_5", byte_cnt4, 5);
        chk("p4_w4_low", w_enable4, 0);
        chk("p4_dflt_no_err", r_error, 0);
        chk("p4_dflt_cnt_5", byte_cnt, 5);
        send_byte(8'h06);
        chk("p4_w4_suppressed", w_enable4, 0);
        chk("p4_dflt_6th_write", w_enable, 1);
        idle(1);
        send_eop();
        pulse_edge();
        chk("p4_rcving4_end", rcving4, 0);
        chk("p4_rcving_end", rcving, 0);
        chk("p4_err4_sticky", r_error4, 1);
        chk("p4_dflt_err", r_error, 0);
        chk("p4_writes4", wr_cnt4 - wr_base4, 5);
        chk("p4_writes", wr_cnt - wr_base, 6);

        // byte_received coincides with EOP at a sample point
        wr_base = wr_cnt;
        pulse_edge();
        chk("p5_err4_cleared", r_error4, 0);
        send_byte(8'h80);
        shifts(8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        chk("p5_wr_strobe", w_enable, 1);
        idle(1);
        chk("p5_w_low", w_enable, 0);
        chk("p5_byte_cnt", byte_cnt, 1);
        chk("p5_r_error", r_error, 0);
        pulse_edge();
        chk("p5_rcving_end", rcving, 0);
        chk("p5_writes", wr_cnt - wr_base, 1);

        // Reset asserted while in STORE
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'h42);
        idle(1);
        send_byte(8'h43);
        chk("p6_in_store", w_enable, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("p6_rst_w_enable", w_enable, 0);
        chk("p6_rst_rcving", rcving, 0);
        chk("p6_rst_byte_cnt", byte_cnt, 0);
        chk("p6_rst_r_error", r_error, 0);

        // IDLE ignores eop, shift_enable and byte_received
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h80);
        idle(1);
        chk("p7_idle_rcving", rcving, 0);
        chk("p7_idle_w_enable", w_enable, 0);
        chk("p7_idle_r_error", r_error, 0);

        // Long gap without sample points in RCV_DATA
        pulse_edge();
        send_byte(8'h80);
        shifts(1);
        idle(95);
        chk("p8_no_err_95", r_error, 0);
        idle(1);
`ifdef RX_TIMEOUT_EN
        chk("p8_timeout_err", r_error, 1);
        chk("p8_rcving_err_idle", rcving, 1);
        pulse_edge();
        chk("p8_rcving_end", rcving, 0);
`else
        chk("p8_no_timeout", r_error, 0);
        idle(40);
        chk("p8_still_no_err", r_error, 0);
        chk("p8_still_rcving", rcving, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64, meaning the maximum data bytes per packet after SYNC.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 96, meaning the idle cycles without shift_enable before abort (used only with RX_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port d_edge, input, 1, a one-cycle pulse from the edge detector on a D+/D- transition.
REQ-006 SHALL have port eop, input, 1, high while SE0 is detected.
REQ-007 SHALL have port shift_enable, input, 1, a one-cycle pulse at each bit-sample point.
REQ-008 SHALL have port byte_received, input, 1, a one-cycle pulse when 8 bits have been shifted.
REQ-009 SHALL have port rcv_data, input, 8, the byte completed with byte_received.
REQ-010 SHALL have port rcving, output, 1, high while a packet is in progress.
REQ-011 SHALL have port w_enable, output, 1, a one-cycle FIFO write strobe for rcv_data.
REQ-012 SHALL have port r_error, output, 1, the sticky packet error flag.
REQ-013 SHALL have port byte_cnt, output, 7, the data bytes stored in the current packet.

Function
REQ-014 SHALL implement states IDLE, SYNC_RCV, RCV_DATA, STORE, EOP_WAIT, ERR_DRAIN, ERR_IDLE; all outputs SHALL be registered/state-decoded with no combinational input-to-output path.
REQ-015 SHALL, in IDLE, on d_edge, go to SYNC_RCV, set rcving=1, clear r_error, and clear byte_cnt and the internal bit counter.
REQ-016 SHALL keep a 3-bit bit counter that increments on shift_enable and clears on byte_received.
REQ-017 SHALL, in SYNC_RCV, on byte_received, go to RCV_DATA if rcv_data==8'h80 and to ERR_DRAIN otherwise; eop&&shift_enable before byte_received SHALL go to ERR_IDLE.
REQ-018 SHALL, in RCV_DATA, on byte_received, go to STORE; w_enable SHALL be high for exactly the one cycle spent in STORE, i.e. 1 cycle after byte_received.
REQ-019 SHALL, in STORE, increment byte_cnt and go to EOP_WAIT if eop&&shift_enable was latched, to ERR_DRAIN if the new byte_cnt > MAX_BYTES (the write still occurs), and to RCV_DATA otherwise.
REQ-020 SHALL, in RCV_DATA, on eop&&shift_enable, go to EOP_WAIT if the bit counter is 0 and to ERR_IDLE otherwise (partial byte).
REQ-021 SHALL, when byte_received and eop&&shift_enable coincide, store the byte first and latch the EOP for the STORE decision.
REQ-022 SHALL, in EOP_WAIT, on d_edge (return to J), go to IDLE with rcving=0.
REQ-023 SHALL, in ERR_DRAIN, set r_error=1, suppress w_enable, and go to ERR_IDLE on eop&&shift_enable.
REQ-024 SHALL, in ERR_IDLE, keep r_error=1, go to IDLE on d_edge with rcving=0, and leave r_error set until the next packet start.
REQ-025 SHALL, in IDLE, ignore eop, shift_enable and byte_received.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force IDLE, rcving=0, w_enable=0, r_error=0, byte_cnt=0, bit counter=0, and the timeout counter to 0; this SHALL hold in any state, including mid-packet and during STORE (no write issued).

Configuration
REQ-027 SHALL, with RX_TIMEOUT_EN defined, clear a cycle counter on shift_enable and increment it otherwise in SYNC_RCV and RCV_DATA; reaching TIMEOUT_CYC SHALL go to ERR_IDLE with r_error=1.
REQ-028 SHALL, with RX_TIMEOUT_EN undefined, contain no timeout counter, leave the port list unchanged, and never abort SYNC_RCV or RCV_DATA by elapsed time.

Verification
REQ-029 SHALL cover: d_edge, SYNC 0x80, bytes 0xA5 and 0x3C, then EOP at bit counter 0 -> two w_enable pulses, each 1 cycle after byte_received; byte_cnt=2; r_error=0; rcving=0 after the closing d_edge.
REQ-030 SHALL cover: SYNC byte 0x81 -> ERR_DRAIN; r_error=1; no w_enable; after EOP and d_edge, IDLE with r_error still 1.
REQ-031 SHALL cover: SYNC, 1 byte, 3 more shift_enable pulses, then EOP -> ERR_IDLE; r_error=1; byte_cnt=1.
REQ-032 SHALL cover: MAX_BYTES=4, 5 data bytes -> 5 writes, then ERR_DRAIN; r_error=1 from the cycle after the 5th STORE.
REQ-033 SHALL cover: byte_received coinciding with eop&&shift_enable -> one w_enable, then EOP_WAIT, r_error=0.
REQ-034 SHALL cover: rst=1 during STORE -> next cycle w_enable=0, rcving=0, byte_cnt=0; and with RX_TIMEOUT_EN, 96 cycles without shift_enable in RCV_DATA -> r_error=1.
